// File: rtl/noc_pkg.sv
// Shared NoC definitions: default address/payload widths and the flit layout.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package noc_pkg;

  localparam int NET_ADDR_W  = 4;
  localparam int BANK_ADDR_W = 8;
  localparam int DATA_W      = 32;
  localparam int DEST_W      = NET_ADDR_W + BANK_ADDR_W;

  // Field order here is the bit order used wherever a flit is packed flat.
  typedef struct packed {
    logic [DEST_W-1:0]     dest;
    logic [NET_ADDR_W-1:0] req;
    logic                  read;
    logic                  write;
    logic [DATA_W-1:0]     data;
  } flit_t;

  localparam int FLIT_W = $bits(flit_t);

endpackage

// File: rtl/noc_flit_fifo.sv
// Circular-buffer FIFO for one arbiter input channel.
// Latency: a push at edge t is visible on pop_dat/count after edge t.
// Backpressure: push is ignored while full (even if popping the same cycle); pop ignored while empty.
//
// Ports:
//   clk, reset      rising-edge clock, synchronous active-high flush
//   push, push_dat  write request and data
//   pop             consume the head entry
//   pop_dat         head entry (valid when !empty)
//   count           occupancy 0..DEPTH
//   full, empty     occupancy flags
module noc_flit_fifo
  import noc_pkg::*;
#(
  parameter int WIDTH = FLIT_W,
  parameter int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_dat,
  output logic [PTR_W:0]   count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count_q == (PTR_W+1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign pop_dat = mem_q[rd_ptr_q];
  assign count   = count_q;

  // DEPTH is a power of two, so pointers wrap by plain overflow.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = push_dat;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: entries are only read once count says they were written.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/noc_rr_output_arbiter.sv
// Merges NUM_IN buffered request channels onto one output link with round-robin fairness.
// Latency: packet accepted at edge t into an empty FIFO with a free output -> out_valid after t+1.
// Backpressure: per-channel in_ready from FIFO occupancy; output register holds while !out_ready.
//
// Ports:
//   clk, reset                          rising-edge clock, synchronous active-high reset
//   in_valid/in_ready [NUM_IN]          per-channel handshake
//   in_dest/in_req/in_read/in_write/in_data  packed per channel, channel i at [i*W +: W]
//   out_valid/out_ready                 output handshake
//   out_dest/out_req/out_read/out_write/out_data  granted packet
//   out_src                             channel that supplied the current output
module noc_rr_output_arbiter #(
  parameter int NUM_IN      = 5,
  parameter int DEPTH       = 4,
  parameter int NET_ADDR_W  = noc_pkg::NET_ADDR_W,
  parameter int BANK_ADDR_W = noc_pkg::BANK_ADDR_W,
  parameter int DATA_W      = noc_pkg::DATA_W,
  localparam int DEST_W     = NET_ADDR_W + BANK_ADDR_W,
  localparam int SRC_W      = $clog2(NUM_IN),
  localparam int PTR_W      = $clog2(DEPTH)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NUM_IN-1:0]            in_valid,
  output logic [NUM_IN-1:0]            in_ready,
  input  logic [NUM_IN*DEST_W-1:0]     in_dest,
  input  logic [NUM_IN*NET_ADDR_W-1:0] in_req,
  input  logic [NUM_IN-1:0]            in_read,
  input  logic [NUM_IN-1:0]            in_write,
  input  logic [NUM_IN*DATA_W-1:0]     in_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [DEST_W-1:0]            out_dest,
  output logic [NET_ADDR_W-1:0]        out_req,
  output logic                         out_read,
  output logic                         out_write,
  output logic [DATA_W-1:0]            out_data,
  output logic [SRC_W-1:0]             out_src
);

  // Same layout as noc_pkg::flit_t, but sized by this instance's parameters.
  typedef struct packed {
    logic [DEST_W-1:0]     dest;
    logic [NET_ADDR_W-1:0] req;
    logic                  read;
    logic                  write;
    logic [DATA_W-1:0]     data;
  } flit_t;

  localparam int FW = $bits(flit_t);

  logic [NUM_IN-1:0] push;
  logic [NUM_IN-1:0] pop;
  logic [NUM_IN-1:0] eligible;
  logic [NUM_IN-1:0] full;
  logic [NUM_IN-1:0] fifo_empty_unused;
  logic [FW-1:0]     head_dat [NUM_IN];
  logic [PTR_W:0]    count    [NUM_IN];

  flit_t             out_flit_q, out_flit_d;
  logic              out_valid_q, out_valid_d;
  logic [SRC_W-1:0]  out_src_q, out_src_d;
  logic [SRC_W-1:0]  rr_ptr_q, rr_ptr_d;

  logic              found;
  logic [SRC_W-1:0]  winner;
  logic [SRC_W-1:0]  idx;
  logic              load;

  for (genvar g = 0; g < NUM_IN; g++) begin : g_ch
    flit_t in_flit;

    assign in_flit = {in_dest[g*DEST_W +: DEST_W],
                      in_req[g*NET_ADDR_W +: NET_ADDR_W],
                      in_read[g],
                      in_write[g],
                      in_data[g*DATA_W +: DATA_W]};

    // in_ready looks only at registered occupancy: a pop this cycle does not free a slot.
    assign in_ready[g] = !reset && !full[g];
    assign push[g]     = in_valid[g] && in_ready[g];
    assign eligible[g] = (count[g] != '0);

    noc_flit_fifo #(
      .WIDTH (FW),
      .DEPTH (DEPTH)
    ) u_fifo (
      .clk      (clk),
      .reset    (reset),
      .push     (push[g]),
      .push_dat (in_flit),
      .pop      (pop[g]),
      .pop_dat  (head_dat[g]),
      .count    (count[g]),
      .full     (full[g]),
      .empty    (fifo_empty_unused[g])
    );
  end

  // Search starts one past the last winner so every backlogged channel is served within NUM_IN grants.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    idx    = '0;
    for (int k = 1; k <= NUM_IN; k++) begin
      idx = SRC_W'((int'(rr_ptr_q) + k) % NUM_IN);
      if (!found && eligible[idx]) begin
        found  = 1'b1;
        winner = idx;
      end
    end
  end

  // Output register reloads whenever it is empty or being drained this cycle.
  always_comb begin
    load        = !out_valid_q || out_ready;
    out_valid_d = out_valid_q;
    out_flit_d  = out_flit_q;
    out_src_d   = out_src_q;
    rr_ptr_d    = rr_ptr_q;
    pop         = '0;
    if (load) begin
      out_valid_d = found;
      if (found) begin
        out_flit_d  = head_dat[winner];
        out_src_d   = winner;
        rr_ptr_d    = winner;
        pop[winner] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      out_flit_q  <= '0;
      out_src_q   <= '0;
      rr_ptr_q    <= SRC_W'(NUM_IN - 1);
    end else begin
      out_valid_q <= out_valid_d;
      out_flit_q  <= out_flit_d;
      out_src_q   <= out_src_d;
      rr_ptr_q    <= rr_ptr_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_dest  = out_flit_q.dest;
  assign out_req   = out_flit_q.req;
  assign out_read  = out_flit_q.read;
  assign out_write = out_flit_q.write;
  assign out_data  = out_flit_q.data;
  assign out_src   = out_src_q;

endmodule

// File: tb/tb_noc_rr_output_arbiter.sv
module tb_noc_rr_output_arbiter;

  localparam int NUM_IN = 5;
  localparam int DEST_W = 12;
  localparam int REQ_W  = 4;
  localparam int DATA_W = 32;

  logic                     clk = 1'b0;
  logic                     reset;
  logic [NUM_IN-1:0]        in_valid;
  logic [NUM_IN-1:0]        in_ready;
  logic [NUM_IN*DEST_W-1:0] in_dest;
  logic [NUM_IN*REQ_W-1:0]  in_req;
  logic [NUM_IN-1:0]        in_read;
  logic [NUM_IN-1:0]        in_write;
  logic [NUM_IN*DATA_W-1:0] in_data;
  logic                     out_valid;
  logic                     out_ready;
  logic [DEST_W-1:0]        out_dest;
  logic [REQ_W-1:0]         out_req;
  logic                     out_read;
  logic                     out_write;
  logic [DATA_W-1:0]        out_data;
  logic [2:0]               out_src;

  int checks = 0;
  int errors = 0;

  noc_rr_output_arbiter dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_dest   (in_dest),
    .in_req    (in_req),
    .in_read   (in_read),
    .in_write  (in_write),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_dest  (out_dest),
    .out_req   (out_req),
    .out_read  (out_read),
    .out_write (out_write),
    .out_data  (out_data),
    .out_src   (out_src)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    in_valid = '0;
    in_dest  = '0;
    in_req   = '0;
    in_read  = '0;
    in_write = '0;
    in_data  = '0;
  endtask

  task automatic set_ch(input int ch, input logic [DEST_W-1:0] d, input logic [REQ_W-1:0] r,
                        input logic rd, input logic wr, input logic [DATA_W-1:0] dat);
    in_valid[ch]                 = 1'b1;
    in_dest[ch*DEST_W +: DEST_W] = d;
    in_req[ch*REQ_W +: REQ_W]    = r;
    in_read[ch]                  = rd;
    in_write[ch]                 = wr;
    in_data[ch*DATA_W +: DATA_W] = dat;
  endtask

  function automatic logic [63:0] obs_out();
    return 64'({out_valid, out_src, out_data});
  endfunction

  function automatic logic [63:0] exp_out(input logic [2:0] src, input logic [31:0] dat);
    return 64'({1'b1, src, dat});
  endfunction

  initial begin
    int s;
    int r;
    logic acc;
    logic hs;

    reset     = 1'b1;
    out_ready = 1'b0;
    clear_in();

    // 1: reset behaviour, queued and held packets discarded
    tick();
    tick();
    chk("rst_in_ready", 64'(in_ready), 64'h0);
    chk("rst_outs", 64'({out_valid, out_src, out_dest, out_req, out_read, out_write, out_data}), 64'h0);
    reset = 1'b0;
    set_ch(0, 12'h001, 4'h1, 1'b0, 1'b1, 32'h111);
    set_ch(1, 12'h002, 4'h2, 1'b1, 1'b0, 32'h222);
    tick();
    clear_in();
    tick();
    chk("pre_rst_out", obs_out(), exp_out(3'd0, 32'h111));
    reset = 1'b1;
    tick();
    chk("mid_rst_in_ready", 64'(in_ready), 64'h0);
    chk("mid_rst_outs", 64'({out_valid, out_src, out_dest, out_req, out_read, out_write, out_data}), 64'h0);
    reset = 1'b0;
    #1;
    chk("post_rst_in_ready", 64'(in_ready), 64'h1F);
    out_ready = 1'b1;
    tick();
    chk("flushed_1", 64'(out_valid), 64'h0);
    tick();
    chk("flushed_2", 64'(out_valid), 64'h0);

    // 2: single packet path, one-cycle latency
    set_ch(2, 12'h3A5, 4'h7, 1'b1, 1'b0, 32'hDEADBEEF);
    tick();
    clear_in();
    chk("single_not_yet", 64'(out_valid), 64'h0);
    tick();
    chk("single_out", obs_out(), exp_out(3'd2, 32'hDEADBEEF));
    chk("single_fields", 64'({out_dest, out_req, out_read, out_write}), 64'({12'h3A5, 4'h7, 1'b1, 1'b0}));
    tick();
    chk("single_idle", 64'(out_valid), 64'h0);
    chk("idle_hold_data", 64'(out_data), 64'hDEADBEEF);

    // 3: fairness, all channels backlogged, order 0..4 three times
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      for (int ch = 0; ch < NUM_IN; ch++)
        set_ch(ch, 12'(ch), 4'(k), 1'b1, 1'b0, 32'hC0DE0000 | 32'(ch << 4) | 32'(k));
      tick();
      if (k > 0)
        chk("rr_seq", obs_out(), exp_out(3'((k-1) % 5), 32'hC0DE0000 | 32'((((k-1) % 5)) << 4) | 32'((k-1) / 5)));
    end
    clear_in();
    for (int n = 2; n < 15; n++) begin
      tick();
      chk("rr_seq", obs_out(), exp_out(3'(n % 5), 32'hC0DE0000 | 32'((n % 5) << 4) | 32'(n / 5)));
    end
    tick();
    chk("rr_done", 64'(out_valid), 64'h0);

    // 4: back-pressure, ch0 fills FIFO while output is held
    out_ready = 1'b0;
    for (int j = 0; j < 5; j++) begin
      set_ch(0, 12'h010, 4'h0, 1'b0, 1'b1, 32'h40 + 32'(j));
      tick();
    end
    chk("bp_full_ready", 64'(in_ready), 64'h1E);
    chk("bp_held", obs_out(), exp_out(3'd0, 32'h40));
    set_ch(0, 12'h010, 4'h0, 1'b0, 1'b1, 32'h99);
    tick();
    chk("bp_refused", 64'(in_ready), 64'h1E);
    chk("bp_held2", obs_out(), exp_out(3'd0, 32'h40));
    clear_in();
    out_ready = 1'b1;
    for (int j = 1; j < 5; j++) begin
      tick();
      chk("bp_drain", obs_out(), exp_out(3'd0, 32'h40 + 32'(j)));
    end
    tick();
    chk("bp_empty", 64'(out_valid), 64'h0);

    // 5: stall hold while ch1 keeps pushing
    out_ready = 1'b0;
    set_ch(1, 12'h020, 4'h1, 1'b1, 1'b0, 32'h50);
    tick();
    set_ch(1, 12'h020, 4'h1, 1'b1, 1'b0, 32'h51);
    tick();
    chk("stall_first", obs_out(), exp_out(3'd1, 32'h50));
    set_ch(1, 12'h020, 4'h1, 1'b1, 1'b0, 32'h52);
    tick();
    chk("stall_hold", obs_out(), exp_out(3'd1, 32'h50));
    set_ch(1, 12'h020, 4'h1, 1'b1, 1'b0, 32'h53);
    tick();
    chk("stall_hold", obs_out(), exp_out(3'd1, 32'h50));
    clear_in();
    tick();
    chk("stall_hold", obs_out(), exp_out(3'd1, 32'h50));
    out_ready = 1'b1;
    for (int j = 1; j < 4; j++) begin
      tick();
      chk("stall_drain", obs_out(), exp_out(3'd1, 32'h50 + 32'(j)));
    end
    tick();
    chk("stall_empty", 64'(out_valid), 64'h0);

    // 6: ch4 streams 10 packets with out_ready toggling; pointers wrap twice
    s = 0;
    r = 0;
    for (int cyc = 0; cyc < 200 && r < 10; cyc++) begin
      if (s < 10) set_ch(4, 12'h040, 4'h4, 1'b0, 1'b0, 32'h60 + 32'(s));
      else clear_in();
      out_ready = cyc[0];
      #1;
      acc = in_valid[4] && in_ready[4];
      hs  = out_valid && out_ready;
      if (hs) chk("wrap_data", obs_out(), exp_out(3'd4, 32'h60 + 32'(r)));
      tick();
      if (acc) s++;
      if (hs) r++;
    end
    clear_in();
    chk("wrap_sent", 64'(s), 64'd10);
    chk("wrap_recv", 64'(r), 64'd10);
    out_ready = 1'b1;
    tick();
    chk("wrap_empty", 64'(out_valid), 64'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
